// File: rtl/regfile_mp.sv
// Multi-port integer register file: NRD combinational reads, NWR synchronous writes,
// optional write-to-read bypass and a per-register pending-write scoreboard.
module regfile_mp #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NWR    = 2,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic                clk_i,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    output logic [NRD-1:0]      rd_busy_o,
    input  logic [NWR-1:0]      wr_en_i,
    input  logic [NWR*AW-1:0]   wr_addr_i,
    input  logic [NWR*XLEN-1:0] wr_data_i,
    input  logic                iss_vld_i,
    input  logic [AW-1:0]       iss_rd_i,
    output logic [NREGS-1:0]    busy_vec_o
);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_d;

    // Ports are applied in ascending order so the highest-index port wins a collision.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] != '0)) begin
                    r_regs[wr_addr_i[w*AW +: AW]] <= wr_data_i[w*XLEN +: XLEN];
                end
            end
        end
    end

    // Retire on write, then mark the new producer; set after clear so set wins.
    always_comb begin
        w_busy_d = r_busy;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en_i[w]) begin
                w_busy_d[wr_addr_i[w*AW +: AW]] = 1'b0;
            end
        end
        if (iss_vld_i) begin
            w_busy_d[iss_rd_i] = 1'b1;
        end
        w_busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_d;
        end
    end

    assign busy_vec_o = r_busy;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic [XLEN-1:0] w_data;
        logic            w_busy;
        logic            w_hit;

        assign w_ra = rd_addr_i[k*AW +: AW];

        always_comb begin
            w_data = r_regs[w_ra];
            w_hit  = 1'b0;
            if ((BYPASS != 0) && rst_n) begin
                for (int w = 0; w < NWR; w++) begin
                    if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] == w_ra)) begin
                        w_data = wr_data_i[w*XLEN +: XLEN];
                        w_hit  = 1'b1;
                    end
                end
            end
            w_busy = r_busy[w_ra];
            // A forwarded result is not a hazard unless a new producer issues alongside it.
            if (w_hit && !(iss_vld_i && (iss_rd_i == w_ra))) begin
                w_busy = 1'b0;
            end
            if (w_ra == '0) begin
                w_data = '0;
                w_busy = 1'b0;
            end
        end

        assign rd_data_o[k*XLEN +: XLEN] = w_data;
        assign rd_busy_o[k]              = w_busy;
    end

endmodule
